// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake and flush.
// Define PIPE_STAGE_REG_SKID_EN for a 2-entry skid buffer with registered ready_o.
module pipe_stage_reg #(
  parameter int unsigned CTRL_WIDTH = 9,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [WIDTH-1:0]      data_o
);

  logic                  valid_q;
  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic [WIDTH-1:0]      data_q;
  logic                  accept;
  logic                  rel;

  assign accept  = valid_i & ready_o;
  assign rel     = valid_q & ready_i;
  assign valid_o = valid_q;
  // Bubbles always decode as NOP downstream.
  assign ctrl_o  = valid_q ? ctrl_q : '0;
  assign data_o  = data_q;

`ifdef PIPE_STAGE_REG_SKID_EN

  typedef enum logic [1:0] {
    EMPTY,
    HALF,
    FULL
  } state_e;

  state_e                state_q;
  logic                  skid_valid_q;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q;
  logic [WIDTH-1:0]      skid_data_q;

  assign ready_o = ~skid_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= EMPTY;
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      data_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else if (flush_i) begin
      state_q      <= EMPTY;
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      data_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= HALF;
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
          end
        end
        HALF: begin
          if (accept && rel) begin
            ctrl_q <= ctrl_i;
            data_q <= data_i;
          end else if (accept) begin
            state_q      <= FULL;
            skid_valid_q <= 1'b1;
            skid_ctrl_q  <= ctrl_i;
            skid_data_q  <= data_i;
          end else if (rel) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        FULL: begin
          // Skid drains into main on the same edge main is released.
          if (rel) begin
            state_q      <= HALF;
            ctrl_q       <= skid_ctrl_q;
            data_q       <= skid_data_q;
            skid_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= EMPTY;
          valid_q      <= 1'b0;
          skid_valid_q <= 1'b0;
        end
      endcase
    end
  end

`else

  assign ready_o = ready_i | ~valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end else if (rel) begin
      valid_q <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: bounded FIFO reference model,
// directed scenarios followed by randomized traffic with flushes and resets.
module tb_pipe_stage_reg;

  localparam int CW = 9;
  localparam int DW = 32;
`ifdef PIPE_STAGE_REG_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          valid_i;
  logic          ready_o;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;
  logic          valid_o;
  logic          ready_i;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;

  beat_t         sb[$];
  logic [DW-1:0] hold;
  int            n_pass  = 0;
  int            n_total = 0;

  pipe_stage_reg #(.CTRL_WIDTH(CW), .WIDTH(DW)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .ctrl_i  (ctrl_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .ctrl_o  (ctrl_o),
    .data_o  (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: compare against the model, then retire/record beats.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("valid_o", 64'(valid_o), 64'(sb.size() != 0));
      if (CAP == 2)
        chk("ready_o", 64'(ready_o), 64'(sb.size() < 2));
      else
        chk("ready_o", 64'(ready_o), 64'(ready_i | (sb.size() == 0)));
      if (sb.size() != 0) begin
        chk("data_o", 64'(data_o), 64'(sb[0].d));
        chk("ctrl_o", 64'(ctrl_o), 64'(sb[0].c));
      end else begin
        chk("ctrl_nop", 64'(ctrl_o), 64'd0);
        chk("data_hold", 64'(data_o), 64'(hold));
      end
      if (flush_i) begin
        sb.delete();
        hold = '0;
      end else begin
        if (valid_o && ready_i && sb.size() != 0) begin
          hold = sb[0].d;
          void'(sb.pop_front());
        end
        if (valid_i && ready_o) sb.push_back('{c: ctrl_i, d: data_i});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  // Hold a beat on the inputs until it is accepted (bounded).
  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
    bit done = 0;
    valid_i = 1'b1;
    ctrl_i  = c;
    data_i  = d;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_i);
      done = ready_o;
      tick();
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    valid_i = 1'b1;
    ready_i = 1'b0;
    ctrl_i  = 9'h1FF;
    data_i  = 32'hDEAD_BEEF;
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ctrl", 64'(ctrl_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    sb.delete();
    hold = '0;
    repeat (2) tick();
    idle();
    ready_i = 1'b1;
    rst_ni  = 1'b1;
  endtask

  task automatic drain();
    idle();
    ready_i = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk_i);
    chk("drain", 64'(sb.size()), 64'd0);
    tick();
  endtask

  initial begin
    flush_i = 1'b0;
    hold    = '0;
    do_reset();
    repeat (3) tick();

    // Back-to-back streaming.
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) send(9'h010 + CW'(i), DW'(i));
    drain();

    // Backpressure after the first beat is delivered.
    fork
      begin
        for (int i = 1; i <= 4; i++) send(9'h020 + CW'(i), DW'(i));
      end
      begin
        repeat (2) @(posedge clk_i);
        #1 ready_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1 ready_i = 1'b1;
      end
    join
    drain();

    // Flush a stalled stage while a new beat is offered.
    ready_i = 1'b0;
    send(9'h005, 32'd5);
`ifdef PIPE_STAGE_REG_SKID_EN
    send(9'h006, 32'd6);
`endif
    flush_i = 1'b1;
    valid_i = 1'b1;
    ctrl_i  = 9'h007;
    data_i  = 32'd7;
    tick();
    idle();
    repeat (3) tick();
    ready_i = 1'b1;
    repeat (2) tick();

    // Single beat followed by a bubble.
    send(9'h0A5, 32'h1234_5678);
    idle();
    repeat (3) tick();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      valid_i = 1'($urandom_range(0, 3) != 0);
      ready_i = 1'($urandom_range(0, 2) != 0);
      flush_i = 1'($urandom_range(0, 31) == 0);
      ctrl_i  = CW'($urandom);
      data_i  = $urandom;
      if (i == 700) begin
        #2;
        do_reset();
      end else begin
        tick();
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
